// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared single-port memory.
interface mem_arbiter_if #(
    parameter int unsigned W = 32
);
    logic         if_req;
    logic [W-1:0] if_addr;
    logic         if_flush;
    logic [W-1:0] if_rdata;
    logic         if_valid;
    logic         if_stall;

    logic         d_en;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_valid;
    logic         d_stall;

    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_ack;

    logic         err;

    modport slave (
        input  if_req, if_addr, if_flush, d_en, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, if_flush, d_en, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory,
// alternating on contention, with fetch squash and a sticky timeout error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_mem_req,   w_mem_req_nxt;
    logic             r_mem_we,    w_mem_we_nxt;
    logic [W-1:0]     r_mem_addr,  w_mem_addr_nxt;
    logic [W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic             r_if_valid,  w_if_valid_nxt;
    logic [W-1:0]     r_if_rdata,  w_if_rdata_nxt;
    logic             r_d_valid,   w_d_valid_nxt;
    logic [W-1:0]     r_d_rdata,   w_d_rdata_nxt;
    logic             r_err,       w_err_nxt;
    logic             r_last_d,    w_last_d_nxt;
    logic             r_squash,    w_squash_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;

    logic             w_busy;
    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_timeout;
    logic             w_done;
    logic             w_squash;

    // Data wins in IDLE unless both are pending and data had the previous grant.
    assign w_busy    = (r_state != S_IDLE);
    assign w_grant_d = !w_busy && bus.d_en && !(bus.if_req && r_last_d);
    assign w_grant_i = !w_busy && bus.if_req && !w_grant_d;
    assign w_timeout = w_busy && !bus.mem_ack && (r_cnt == CNT_LAST);
    assign w_done    = w_busy && (bus.mem_ack || w_timeout);
    assign w_squash  = r_squash || bus.if_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = S_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_valid_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_valid_nxt   = 1'b0;
        w_d_rdata_nxt   = r_d_rdata;
        w_err_nxt       = r_err;
        w_last_d_nxt    = r_last_d;
        w_squash_nxt    = r_squash;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.d_we;
                    w_mem_addr_nxt  = bus.d_addr;
                    w_mem_wdata_nxt = bus.d_wdata;
                    w_last_d_nxt    = 1'b1;
                    w_squash_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                end else if (w_grant_i) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = bus.if_addr;
                    w_last_d_nxt    = 1'b0;
                    w_squash_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                end
            end
            S_BUSY_I: begin
                w_squash_nxt = w_squash;
                if (w_done) begin
                    w_mem_req_nxt = 1'b0;
                    w_squash_nxt  = 1'b0;
                    w_err_nxt     = r_err || w_timeout;
                    if (!w_squash) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = w_timeout ? '0 : bus.mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_BUSY_D: begin
                if (w_done) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_d_valid_nxt = 1'b1;
                    w_err_nxt     = r_err || w_timeout;
                    if (w_timeout) begin
                        w_d_rdata_nxt = '0;
                    end else if (!r_mem_we) begin
                        w_d_rdata_nxt = bus.mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_valid   <= 1'b0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
            r_last_d    <= 1'b0;
            r_squash    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_valid   <= w_d_valid_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_err       <= w_err_nxt;
            r_last_d    <= w_last_d_nxt;
            r_squash    <= w_squash_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.err       = r_err;
    assign bus.if_stall  = bus.if_req & ~r_if_valid;
    assign bus.d_stall   = bus.d_en & ~r_d_valid;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, data and pulses.
module tb_mem_arbiter;
    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic         m_last_d;
    logic [W-1:0] exp_if_rdata;
    logic [W-1:0] exp_d_rdata;

    mem_arbiter_if #(.W(W)) bus ();

    mem_arbiter #(.TIMEOUT(TO), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.d_en      = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #12;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.d_valid,
             bus.if_rdata, bus.d_rdata, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h iv=%b dv=%b ird=%h drd=%h err=%b",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.d_valid,
                     bus.if_rdata, bus.d_rdata, bus.err);
        end
        total++;
        if ({bus.if_stall, bus.d_stall} !== 2'b00) begin
            bad++;
            $display("FAIL reset_stall: got %b want 00", {bus.if_stall, bus.d_stall});
        end
        @(negedge clk);
        rst = 1'b1;
        cyc();
        m_last_d     = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    task automatic test_single_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        cyc();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            bad++;
            $display("FAIL fetch_issue: req=%b we=%b addr=%h want 1 0 00000010", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        total++;
        if (bus.if_stall !== 1'b1) begin
            bad++;
            $display("FAIL fetch_stall_busy: got %b want 1", bus.if_stall);
        end
        cyc();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.if_valid} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
            bad++;
            $display("FAIL fetch_hold: req=%b we=%b addr=%h iv=%b", bus.mem_req, bus.mem_we, bus.mem_addr, bus.if_valid);
        end
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        cyc();
        bus.mem_ack = 1'b0;
        exp_if_rdata = 32'hDEADBEEF;
        total++;
        if ({bus.if_valid, bus.if_rdata, bus.if_stall, bus.mem_req} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fetch_valid: iv=%b rdata=%h stall=%b req=%b want 1 deadbeef 0 0",
                     bus.if_valid, bus.if_rdata, bus.if_stall, bus.mem_req);
        end
        bus.if_req = 1'b0;
        cyc();
        total++;
        if ({bus.if_valid, bus.mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_pulse_once: iv=%b req=%b want 0 0", bus.if_valid, bus.mem_req);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] seen[$];
        logic [W-1:0] want_order[4];
        int nd = 0;
        int ni = 0;
        want_order[0] = 32'h4;  want_order[1] = 32'h20;
        want_order[2] = 32'h4;  want_order[3] = 32'h20;
        bus.d_en = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4; bus.d_wdata = 32'h55;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A50001;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (bus.mem_req === 1'b1) begin
                seen.push_back(bus.mem_addr);
                if (seen.size() == 1) begin
                    total++;
                    if ({bus.mem_we, bus.mem_wdata} !== {1'b1, 32'h55}) begin
                        bad++;
                        $display("FAIL contention_first_write: we=%b wdata=%h want 1 00000055", bus.mem_we, bus.mem_wdata);
                    end
                end
            end
            nd += int'(bus.d_valid);
            ni += int'(bus.if_valid);
        end
        idle_inputs();
        m_last_d     = 1'b0;
        exp_if_rdata = 32'hA5A50001;
        total++;
        if (seen.size() != 4) begin
            bad++;
            $display("FAIL contention_grant_count: got %0d want 4", seen.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                total++;
                if (seen[g] !== want_order[g]) begin
                    bad++;
                    $display("FAIL contention_order[%0d]: addr %h want %h", g, seen[g], want_order[g]);
                end
            end
        end
        total++;
        if (nd != 2 || ni != 2) begin
            bad++;
            $display("FAIL contention_pulses: d=%0d i=%0d want 2 2", nd, ni);
        end
        total++;
        if (bus.d_rdata !== exp_d_rdata || bus.if_rdata !== exp_if_rdata) begin
            bad++;
            $display("FAIL contention_rdata: d=%h i=%h want %h %h", bus.d_rdata, bus.if_rdata, exp_d_rdata, exp_if_rdata);
        end
        cyc();
        total++;
        if ({bus.mem_req, bus.if_valid, bus.d_valid} !== 3'b000) begin
            bad++;
            $display("FAIL contention_settle: req=%b iv=%b dv=%b", bus.mem_req, bus.if_valid, bus.d_valid);
        end
    endtask

    task automatic test_flush();
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        cyc();
        bus.if_flush = 1'b1;
        cyc();
        bus.if_flush = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234;
        cyc();
        bus.mem_ack = 1'b0; bus.if_req = 1'b0;
        m_last_d = 1'b0;
        total++;
        if ({bus.if_valid, bus.mem_req, bus.if_rdata} !== {1'b0, 1'b0, exp_if_rdata}) begin
            bad++;
            $display("FAIL flush_squash: iv=%b req=%b rdata=%h want 0 0 %h", bus.if_valid, bus.mem_req, bus.if_rdata, exp_if_rdata);
        end
        bus.d_en = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
        cyc();
        total++;
        if ({bus.mem_req, bus.mem_addr, bus.if_valid} !== {1'b1, 32'h8, 1'b0}) begin
            bad++;
            $display("FAIL flush_back_to_idle: req=%b addr=%h iv=%b", bus.mem_req, bus.mem_addr, bus.if_valid);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE0008;
        cyc();
        idle_inputs();
        m_last_d    = 1'b1;
        exp_d_rdata = 32'hCAFE0008;
        total++;
        if ({bus.d_valid, bus.d_rdata} !== {1'b1, exp_d_rdata}) begin
            bad++;
            $display("FAIL flush_next_read: dv=%b rdata=%h want 1 %h", bus.d_valid, bus.d_rdata, exp_d_rdata);
        end
        cyc();
    endtask

    task automatic test_stray_ack();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++;
            if ({bus.mem_req, bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata} !==
                {3'b000, exp_if_rdata, exp_d_rdata}) begin
                bad++;
                $display("FAIL stray_ack[%0d]: req=%b iv=%b dv=%b ird=%h drd=%h", c,
                         bus.mem_req, bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata);
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic         want_i, want_d, gnt_d, dwe, flush_any, exp_iv, exp_dv, exp_we;
            logic [W-1:0] rd, exp_addr;
            int           k, n;
            want_i = 1'($urandom_range(0, 1));
            want_d = 1'($urandom_range(0, 1));
            if (!want_i && !want_d) want_d = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            bus.if_req  = want_i; bus.if_addr = $urandom;
            bus.d_en    = want_d; bus.d_we    = dwe;
            bus.d_addr  = $urandom; bus.d_wdata = $urandom;
            while (want_i || want_d) begin
                gnt_d    = want_d && !(want_i && m_last_d);
                m_last_d = gnt_d;
                exp_addr = gnt_d ? bus.d_addr : bus.if_addr;
                exp_we   = gnt_d && dwe;
                n = 0;
                while (bus.mem_req !== 1'b1 && n < 4) begin
                    cyc();
                    n++;
                end
                total++;
                if (n != 1) begin
                    bad++;
                    $display("FAIL rand_issue_latency it=%0d: %0d cycles want 1", it, n);
                end
                total++;
                if ({bus.mem_addr, bus.mem_we} !== {exp_addr, exp_we}) begin
                    bad++;
                    $display("FAIL rand_issue it=%0d: addr=%h we=%b want %h %b", it, bus.mem_addr, bus.mem_we, exp_addr, exp_we);
                end
                if (exp_we) begin
                    total++;
                    if (bus.mem_wdata !== bus.d_wdata) begin
                        bad++;
                        $display("FAIL rand_wdata it=%0d: %h want %h", it, bus.mem_wdata, bus.d_wdata);
                    end
                end
                k         = int'($urandom_range(0, 4));
                flush_any = ($urandom_range(0, 3) == 0);
                bus.if_flush = flush_any;
                for (int j = 0; j < k; j++) begin
                    cyc();
                    bus.if_flush = 1'b0;
                    total++;
                    if ({bus.mem_req, bus.mem_addr, bus.if_valid, bus.d_valid} !== {1'b1, exp_addr, 2'b00}) begin
                        bad++;
                        $display("FAIL rand_busy it=%0d: req=%b addr=%h iv=%b dv=%b", it,
                                 bus.mem_req, bus.mem_addr, bus.if_valid, bus.d_valid);
                    end
                end
                rd = $urandom;
                bus.mem_ack = 1'b1; bus.mem_rdata = rd;
                cyc();
                bus.mem_ack = 1'b0; bus.if_flush = 1'b0;
                if (gnt_d) begin
                    exp_dv = 1'b1; exp_iv = 1'b0;
                    if (!dwe) exp_d_rdata = rd;
                end else begin
                    exp_dv = 1'b0; exp_iv = !flush_any;
                    if (!flush_any) exp_if_rdata = rd;
                end
                total++;
                if ({bus.if_valid, bus.d_valid, bus.mem_req} !== {exp_iv, exp_dv, 1'b0}) begin
                    bad++;
                    $display("FAIL rand_complete it=%0d: iv=%b dv=%b req=%b want %b %b 0", it,
                             bus.if_valid, bus.d_valid, bus.mem_req, exp_iv, exp_dv);
                end
                total++;
                if ({bus.if_rdata, bus.d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
                    bad++;
                    $display("FAIL rand_rdata it=%0d: i=%h d=%h want %h %h", it,
                             bus.if_rdata, bus.d_rdata, exp_if_rdata, exp_d_rdata);
                end
                total++;
                if ({bus.if_stall, bus.d_stall} !== {want_i & ~exp_iv, want_d & ~exp_dv}) begin
                    bad++;
                    $display("FAIL rand_stall it=%0d: got %b want %b", it, {bus.if_stall, bus.d_stall},
                             {want_i & ~exp_iv, want_d & ~exp_dv});
                end
                if (gnt_d) begin
                    want_d = 1'b0; bus.d_en = 1'b0;
                end else begin
                    want_i = 1'b0; bus.if_req = 1'b0;
                end
            end
            cyc();
            total++;
            if ({bus.if_valid, bus.d_valid, bus.mem_req, bus.err} !== 4'b0000) begin
                bad++;
                $display("FAIL rand_settle it=%0d: iv=%b dv=%b req=%b err=%b", it,
                         bus.if_valid, bus.d_valid, bus.mem_req, bus.err);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bus.d_en = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hC;
        cyc();
        while (bus.mem_req === 1'b1 && n < 40) begin
            n++;
            if (bus.d_valid !== 1'b0 || bus.err !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL timeout_early: cycle %0d dv=%b err=%b", n, bus.d_valid, bus.err);
            end
            cyc();
        end
        total++;
        if (n != int'(TO)) begin
            bad++;
            $display("FAIL timeout_busy_cycles: %0d want %0d", n, TO);
        end
        total++;
        if ({bus.d_valid, bus.d_rdata, bus.err} !== {1'b1, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL timeout_result: dv=%b rdata=%h err=%b want 1 0 1", bus.d_valid, bus.d_rdata, bus.err);
        end
        bus.d_en = 1'b0;
        exp_d_rdata = '0;
        m_last_d    = 1'b1;
        for (int c = 0; c < 3; c++) cyc();
        total++;
        if ({bus.err, bus.d_valid} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_err_sticky: err=%b dv=%b want 1 0", bus.err, bus.d_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_reset: err=%b want 0", bus.err);
        end
        cyc();
        rst = 1'b1;
        m_last_d = 1'b0; exp_if_rdata = '0; exp_d_rdata = '0;
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.d_en = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h77;
        cyc();
        total++;
        if ({bus.mem_req, bus.mem_we} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_issue: req=%b we=%b want 1 1", bus.mem_req, bus.mem_we);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b00, 32'h0}) begin
            bad++;
            $display("FAIL rstmid_async: req=%b we=%b addr=%h want 0 0 0", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.d_en = 1'b0;
        cyc();
        rst = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++;
            if ({bus.mem_req, bus.if_valid, bus.d_valid, bus.d_rdata} !== {3'b000, 32'h0}) begin
                bad++;
                $display("FAIL rstmid_stray_ack[%0d]: req=%b iv=%b dv=%b drd=%h", c,
                         bus.mem_req, bus.if_valid, bus.d_valid, bus.d_rdata);
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_flush();
        test_stray_ack();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: number of BUSY cycles without mem_ack before a transaction is abandoned.
REQ-002 Parameter W, default 32: address and data width.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port if_req, input, 1: instruction-fetch read request.
REQ-006 Port if_addr, input, W: word address of the instruction fetch.
REQ-007 Port if_flush, input, 1: fetch squash; suppresses delivery of the pending fetch.
REQ-008 Port if_rdata, output, W: fetched instruction.
REQ-009 Port if_valid, output, 1: one-cycle pulse; if_rdata is valid.
REQ-010 Port if_stall, output, 1: fetch not yet serviced.
REQ-011 Port d_en, input, 1: data access request.
REQ-012 Port d_we, input, 1: data write enable.
REQ-013 Port d_addr, input, W: data word address.
REQ-014 Port d_wdata, input, W: store data.
REQ-015 Port d_rdata, output, W: load data.
REQ-016 Port d_valid, output, 1: one-cycle pulse; data access complete.
REQ-017 Port d_stall, output, 1: data access not yet serviced.
REQ-018 Port mem_req, output, 1: request to the shared single-port memory.
REQ-019 Port mem_we, output, 1: memory write.
REQ-020 Port mem_addr, output, W: memory address.
REQ-021 Port mem_wdata, output, W: memory write data.
REQ-022 Port mem_rdata, input, W: memory read data.
REQ-023 Port mem_ack, input, 1: memory completion, one cycle.
REQ-024 Port err, output, 1: sticky flag set on timeout.

Function
REQ-025 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-026 In IDLE, with d_en=1, the FSM SHALL latch d_addr, d_we and d_wdata and enter BUSY_D, except as stated in REQ-027.
REQ-027 If d_en=1, if_req=1 and the last grant was D, the FSM SHALL latch if_addr and enter BUSY_I instead.
REQ-028 In IDLE, with only if_req=1, the FSM SHALL latch if_addr and enter BUSY_I.
REQ-029 The last-grant bit SHALL update on every issue.
REQ-030 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered outputs, driven from the latched request, and stable throughout BUSY_x.
REQ-031 mem_we SHALL be 0 in BUSY_I.
REQ-032 On mem_ack in BUSY_x, the block SHALL drop mem_req on the next edge, return to IDLE and pulse x_valid for exactly one cycle.
REQ-033 On a read completion, the block SHALL register mem_rdata into x_rdata.
REQ-034 Latency: request in IDLE at cycle t -> mem_req=1 at t+1 -> ack at t+k -> x_valid=1 at t+k+1 -> earliest next mem_req at t+k+2.
REQ-035 For a write, d_valid SHALL pulse and d_rdata SHALL hold its previous value.
REQ-036 if_stall SHALL equal if_req & ~if_valid, combinationally.
REQ-037 d_stall SHALL equal d_en & ~d_valid, combinationally.
REQ-038 If if_flush=1 in any cycle of BUSY_I, the block SHALL mark the fetch squashed: the transaction completes on memory, but if_valid stays 0 and if_rdata is unchanged.
REQ-039 The block SHALL ignore if_flush in IDLE and in BUSY_D.
REQ-040 The block SHALL ignore mem_ack in IDLE.
REQ-041 The block SHALL not sample new requests while in BUSY_x; requests are held by the requester via the stall outputs.
REQ-042 A 5-bit wait counter SHALL clear on issue and increment each BUSY cycle without mem_ack.
REQ-043 When the wait counter reaches TIMEOUT, the block SHALL drop mem_req, set err, return to IDLE, and pulse x_valid with x_rdata=0 (for a squashed fetch, no pulse).
REQ-044 err SHALL clear only on reset.

Reset
REQ-045 On rst=0, asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, err=0, last-grant=I, counter=0.
REQ-046 Reset during BUSY_x SHALL abandon the transaction; an mem_ack arriving after reset release SHALL be ignored.

Verification
REQ-047 Single fetch: if_req=1, if_addr=0x10, ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x10 and mem_we=0 while busy; if_valid pulses once with if_rdata=0xDEADBEEF; if_stall low in the valid cycle.
REQ-048 Contention: d_en, d_we=1, d_addr=0x4, d_wdata=0x55 and if_req all held high, immediate acks -> grants in order D, I, D, I; first mem_we=1 with mem_wdata=0x55; d_rdata unchanged.
REQ-049 Flush: BUSY_I with if_flush pulsed, then ack with 0x1234 -> no if_valid pulse; if_rdata unchanged; state returns to IDLE.
REQ-050 Timeout: d_en=1 read, mem_ack held 0 -> mem_req drops after 16 busy cycles; err=1; d_valid pulses with d_rdata=0; err remains 1 until rst=0.
REQ-051 Reset mid-transaction: rst=0 in BUSY_D -> mem_req=0 immediately without a clock edge; a stray ack after release produces no valid pulse.
REQ-052 Stray ack: mem_ack=1 in IDLE with no requests -> no state change and no valid pulse.
